// File: rtl/spi_nor_pkg.sv
// Shared definitions for the SPI NOR responder: command opcodes, FSM states, erased byte value.
package spi_nor_pkg;

  localparam logic [7:0] CMD_READ    = 8'h01;
  localparam logic [7:0] CMD_PROG    = 8'h02;
  localparam logic [7:0] CMD_WRDI    = 8'h04;
  localparam logic [7:0] CMD_RDSR    = 8'h05;
  localparam logic [7:0] CMD_WREN    = 8'h06;
  localparam logic [7:0] ERASED_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDATA,
    STAT,
    IGNORE
  } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Registers the SPI pins once on the system clock and derives single-cycle
// s_clk rise/fall pulses plus a chip-select deassert pulse.
module spi_edge_sync #(
  parameter int SPI_W = 8
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_sclk,
  input  logic             i_css,
  input  logic [SPI_W-1:0] i_mosi,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_css,
  output logic             o_css_deassert,
  output logic [SPI_W-1:0] o_mosi
);

  logic             r_sclk;
  logic             r_sclk_prev;
  logic             r_css;
  logic             r_css_prev;
  logic [SPI_W-1:0] r_mosi;

  // Chip select resets to its idle (high) level so no spurious deassert pulse appears.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_sclk      <= 1'b0;
      r_sclk_prev <= 1'b0;
      r_css       <= 1'b1;
      r_css_prev  <= 1'b1;
      r_mosi      <= '0;
    end else begin
      r_sclk      <= i_sclk;
      r_sclk_prev <= r_sclk;
      r_css       <= i_css;
      r_css_prev  <= r_css;
      r_mosi      <= i_mosi;
    end
  end

  assign o_rise         = r_sclk & ~r_sclk_prev;
  assign o_fall         = ~r_sclk & r_sclk_prev;
  assign o_css          = r_css;
  assign o_css_deassert = r_css & ~r_css_prev;
  assign o_mosi         = r_mosi;

endmodule

// File: rtl/spi_nor_responder.sv
// Byte-lane SPI NOR flash target with an internal erased-to-FF array.
// Define FLASH_PAGE_WRAP_EN to make program data wrap inside a 2**PAGE_W page.
module spi_nor_responder
  import spi_nor_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int SPI_W  = 8,
  parameter int PAGE_W = 8
) (
  input  logic             p_clk,
  input  logic             p_reset,
  input  logic             s_clk,
  input  logic             s_css,
  input  logic [SPI_W-1:0] s_mosi,
  output logic [SPI_W-1:0] s_miso,
  output logic             wel,
  output logic             busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'((64'd1 << PAGE_W) - 64'd1);

  logic             w_rise;
  logic             w_fall;
  logic             w_css;
  logic             w_css_deassert;
  logic [SPI_W-1:0] w_mosi;
  logic             w_we;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [ADDR_W-1:0] w_waddr_next;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_byte_cnt;
  logic              r_is_read;
  logic              r_wr;
  logic              r_prog_seen;
  logic [SPI_W-1:0]  r_miso;
  logic              r_wel;
  logic              r_busy;
  logic [SPI_W-1:0]  r_rd_byte;
  logic [SPI_W-1:0]  r_mem [DEPTH];

  spi_edge_sync #(.SPI_W(SPI_W)) u_edge_sync (
    .i_clk          (p_clk),
    .i_srst         (p_reset),
    .i_sclk         (s_clk),
    .i_css          (s_css),
    .i_mosi         (s_mosi),
    .o_rise         (w_rise),
    .o_fall         (w_fall),
    .o_css          (w_css),
    .o_css_deassert (w_css_deassert),
    .o_mosi         (w_mosi)
  );

  assign w_addr_inc = r_addr + 1'b1;

`ifdef FLASH_PAGE_WRAP_EN
  // Page program: only the in-page offset advances, the page number is held.
  assign w_waddr_next = (r_addr & ~PAGE_MASK) | (w_addr_inc & PAGE_MASK);
`else
  assign w_waddr_next = w_addr_inc;
`endif

  // A rise coinciding with chip-select deassert is dropped because w_css gates it.
  assign w_we = (r_state == WDATA) && w_rise && !w_css && r_wr;

  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= ERASED_BYTE;
      end
    end else if (w_we) begin
      r_mem[r_addr] <= r_mem[r_addr] & w_mosi;
    end
  end

  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      r_rd_byte <= '0;
    end else begin
      r_rd_byte <= r_mem[r_addr];
    end
  end

  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_byte_cnt  <= '0;
      r_is_read   <= 1'b0;
      r_wr        <= 1'b0;
      r_prog_seen <= 1'b0;
      r_miso      <= '0;
      r_wel       <= 1'b0;
      r_busy      <= 1'b0;
    end else if (w_css) begin
      r_state     <= IDLE;
      r_miso      <= '0;
      r_busy      <= 1'b0;
      r_prog_seen <= 1'b0;
      if (w_css_deassert && r_prog_seen) begin
        r_wel <= 1'b0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= CMD;
          r_busy  <= 1'b1;
        end
        CMD: begin
          if (w_rise) begin
            r_byte_cnt <= '0;
            unique case (w_mosi)
              CMD_WREN: begin
                r_wel   <= 1'b1;
                r_state <= IGNORE;
              end
              CMD_WRDI: begin
                r_wel   <= 1'b0;
                r_state <= IGNORE;
              end
              CMD_RDSR: r_state <= STAT;
              CMD_PROG: begin
                r_state     <= ADDR;
                r_is_read   <= 1'b0;
                r_wr        <= r_wel;
                r_prog_seen <= 1'b1;
              end
              CMD_READ: begin
                r_state   <= ADDR;
                r_is_read <= 1'b1;
              end
              default: r_state <= IGNORE;
            endcase
          end
        end
        ADDR: begin
          if (w_rise) begin
            // MSB-first shift; truncation keeps only the implemented address bits.
            r_addr     <= ADDR_W'({r_addr, w_mosi});
            r_byte_cnt <= r_byte_cnt + 1'b1;
            if (r_byte_cnt == 2'd2) begin
              r_state <= r_is_read ? RDATA : WDATA;
            end
          end
        end
        WDATA: begin
          if (w_rise) begin
            r_addr <= w_waddr_next;
          end
        end
        RDATA: begin
          if (w_fall) begin
            r_miso <= r_rd_byte;
            r_addr <= w_addr_inc;
          end
        end
        STAT: begin
          if (w_fall) begin
            r_miso <= SPI_W'({r_wel, 1'b0});
          end
        end
        IGNORE: r_miso <= '0;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_miso = r_miso;
  assign wel    = r_wel;
  assign busy   = r_busy;

endmodule

// File: tb/tb_spi_nor_responder.sv
// Directed bench for spi_nor_responder: drives byte-wide SPI frames and checks
// returned read/status bytes, wel and busy against hand-computed values.
module tb_spi_nor_responder;

  logic       p_clk   = 1'b0;
  logic       p_reset = 1'b1;
  logic       s_clk   = 1'b0;
  logic       s_css   = 1'b1;
  logic [7:0] s_mosi  = 8'h00;
  logic [7:0] s_miso;
  logic       wel;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 p_clk = ~p_clk;

  spi_nor_responder #(.ADDR_W(8), .SPI_W(8), .PAGE_W(8)) dut (
    .p_clk   (p_clk),
    .p_reset (p_reset),
    .s_clk   (s_clk),
    .s_css   (s_css),
    .s_mosi  (s_mosi),
    .s_miso  (s_miso),
    .wel     (wel),
    .busy    (busy)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
    end else begin
      $display("ok   %s: %02h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge p_clk);
  endtask

  // One SPI byte: rx is what the controller would sample at this byte's rise.
  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    s_mosi = tx;
    tick(2);
    rx = s_miso;
    s_clk = 1'b1;
    tick(4);
    s_clk = 1'b0;
    tick(4);
  endtask

  task automatic cs_lo();
    s_css = 1'b0;
    tick(3);
  endtask

  task automatic cs_hi();
    s_css = 1'b1;
    tick(4);
  endtask

  task automatic cmd_addr(input logic [7:0] cmd, input logic [23:0] addr);
    logic [7:0] rx;
    xfer(cmd, rx);
    xfer(addr[23:16], rx);
    xfer(addr[15:8], rx);
    xfer(addr[7:0], rx);
  endtask

  task automatic single_cmd(input logic [7:0] cmd);
    logic [7:0] rx;
    cs_lo();
    xfer(cmd, rx);
    cs_hi();
  endtask

  task automatic do_read(input string tag, input logic [23:0] addr,
                         input logic [7:0] e0, input logic [7:0] e1);
    logic [7:0] rx;
    cs_lo();
    cmd_addr(8'h01, addr);
    xfer(8'h00, rx);
    check({tag, "_b0"}, rx, e0);
    xfer(8'h00, rx);
    check({tag, "_b1"}, rx, e1);
    cs_hi();
  endtask

  task automatic do_prog(input logic [23:0] addr, input int n,
                         input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] rx;
    cs_lo();
    cmd_addr(8'h02, addr);
    xfer(b0, rx);
    if (n > 1) xfer(b1, rx);
    cs_hi();
  endtask

  task automatic do_rdsr(input string tag, input logic [7:0] exp);
    logic [7:0] rx;
    cs_lo();
    xfer(8'h05, rx);
    xfer(8'h00, rx);
    check(tag, rx, exp);
    cs_hi();
  endtask

  initial begin
    logic [7:0] rx;
    tick(4);
    check("rst_miso", s_miso, 8'h00);
    check("rst_wel", {7'b0, wel}, 8'h00);
    check("rst_busy", {7'b0, busy}, 8'h00);
    p_reset = 1'b0;
    tick(3);

    // Erased array reads back FF
    cs_lo();
    check("busy_in_frame", {7'b0, busy}, 8'h01);
    cmd_addr(8'h01, 24'h000010);
    xfer(8'h00, rx);
    check("erased_b0", rx, 8'hFF);
    xfer(8'h00, rx);
    check("erased_b1", rx, 8'hFF);
    cs_hi();
    check("erased_wel", {7'b0, wel}, 8'h00);
    check("idle_busy", {7'b0, busy}, 8'h00);

    // Enabled program, then read back
    single_cmd(8'h06);
    check("wren_wel", {7'b0, wel}, 8'h01);
    do_prog(24'h000000, 2, 8'hA5, 8'h3C);
    check("prog_clears_wel", {7'b0, wel}, 8'h00);
    do_read("prog_rd", 24'h000000, 8'hA5, 8'h3C);

    // Program without WREN leaves the array alone
    do_prog(24'h000020, 1, 8'h00, 8'h00);
    do_read("nowren_rd", 24'h000020, 8'hFF, 8'hFF);

    // Successive programs AND together: F0 & 3F = 30
    single_cmd(8'h06);
    do_prog(24'h000040, 1, 8'hF0, 8'h00);
    single_cmd(8'h06);
    do_prog(24'h000040, 1, 8'h3F, 8'h00);
    do_read("and_rd", 24'h000040, 8'h30, 8'hFF);

    // Status register
    single_cmd(8'h06);
    do_rdsr("rdsr_wel1", 8'h02);
    single_cmd(8'h04);
    do_rdsr("rdsr_wel0", 8'h00);

    // Unknown command is ignored and returns 00
    cs_lo();
    xfer(8'h9F, rx);
    xfer(8'h00, rx);
    check("ignore_miso", rx, 8'h00);
    cs_hi();

    // Reset re-erases the array
    p_reset = 1'b1;
    tick(3);
    p_reset = 1'b0;
    tick(2);
    do_read("reerase_rd", 24'h000000, 8'hFF, 8'hFF);

    // Address wrap 0xFF -> 0x00 for both program and read
    single_cmd(8'h06);
    do_prog(24'h0000FF, 2, 8'h11, 8'h22);
    do_read("wrap_rd", 24'h0000FF, 8'h11, 8'h22);
    do_read("hi_addr_ignored", 24'h1234FF, 8'h11, 8'h22);

    // Abort after two address bytes
    cs_lo();
    xfer(8'h01, rx);
    xfer(8'h00, rx);
    xfer(8'h00, rx);
    cs_hi();
    check("abort_busy", {7'b0, busy}, 8'h00);
    check("abort_miso", s_miso, 8'h00);
    single_cmd(8'h06);
    cs_lo();
    xfer(8'h02, rx);
    xfer(8'h00, rx);
    xfer(8'h00, rx);
    cs_hi();
    check("abort_prog_wel", {7'b0, wel}, 8'h00);
    do_read("abort_nochange", 24'h0000FF, 8'h11, 8'h22);

    // Reset mid-transaction
    cs_lo();
    cmd_addr(8'h01, 24'h0000FF);
    xfer(8'h00, rx);
    p_reset = 1'b1;
    tick(2);
    check("midrst_busy", {7'b0, busy}, 8'h00);
    check("midrst_miso", s_miso, 8'h00);
    s_css = 1'b1;
    tick(2);
    p_reset = 1'b0;
    tick(3);
    do_read("midrst_erased", 24'h0000FF, 8'hFF, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
